rr_shared_rom: RTL and testbench

//  Parametrised synchronous ROM shared by NUM_CH read clients through a

---
 rtl/rr_shared_rom_pkg.sv | 9 +
 rtl/rr_shared_rom_arbiter.sv | 49 ++++
 rtl/rr_shared_rom.sv | 123 ++++++++++++
 tb/tb_rr_shared_rom.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_shared_rom_pkg.sv
// Shared constants and helpers for the round-robin shared ROM and its arbiter.
package rr_shared_rom_pkg;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_shared_rom_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating priority pointer.
module rr_arbiter
  import rr_shared_rom_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int CH_W = clog2_min1(N);
  localparam logic [CH_W:0] N_W = (CH_W+1)'(N);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gnt_idx;
  logic            found;
  logic [CH_W-1:0] cand [N];

  // cand[g] is the channel examined g-th, starting from ptr and wrapping.
  for (genvar g = 0; g < N; g++) begin : g_cand
    logic [CH_W:0] sum;
    assign sum     = {1'b0, ptr} + (CH_W+1)'(g);
    assign cand[g] = (sum >= N_W) ? CH_W'(sum - N_W) : sum[CH_W-1:0];
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[cand[i]]) begin
        found   = 1'b1;
        gnt_idx = cand[i];
      end
    end
    if (found && !rst) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == CH_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_shared_rom.sv
// Synchronous ROM shared by NUM_CH read clients through a round-robin arbiter.
// Valid/ready: a read is accepted when req[i] & gnt[i]; result returns as a one-cycle rvalid pulse.
module rr_shared_rom
  import rr_shared_rom_pkg::*;
#(
  parameter string INIT_FILE  = "",
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 11,
  parameter int    DEPTH      = 2048,
  parameter int    NUM_CH     = 2,
  parameter int    OUT_REG    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rerr
);

  localparam int CH_W  = clog2_min1(NUM_CH);
  localparam int IDX_W = clog2_min1(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  logic [CH_W-1:0]       sel_ch;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      rd_idx;

  always_comb begin
    sel_ch   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_ch   = CH_W'(i);
        sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Out-of-range reads fetch word 0 and are masked, so the index never exceeds DEPTH-1.
  assign accept   = |gnt;
  assign in_range = {1'b0, sel_addr} < DEPTH_W;
  assign rd_idx   = in_range ? sel_addr[IDX_W-1:0] : '0;

  logic                  s1_valid;
  logic [CH_W-1:0]       s1_ch;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_err   <= 1'b0;
      rom_q    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ch  <= sel_ch;
        s1_err <= !in_range;
        rom_q  <= mem[rd_idx];
      end
    end
  end

  assign s1_data = s1_err ? '0 : rom_q;

  logic                  o_valid;
  logic [CH_W-1:0]       o_ch;
  logic                  o_err;
  logic [DATA_WIDTH-1:0] o_data;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        o_valid <= 1'b0;
        o_ch    <= '0;
        o_err   <= 1'b0;
        o_data  <= '0;
      end else begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_ch   <= s1_ch;
          o_err  <= s1_err;
          o_data <= s1_data;
        end
      end
    end
  end else begin : g_no_out_reg
    assign o_valid = s1_valid;
    assign o_ch    = s1_ch;
    assign o_err   = s1_err;
    assign o_data  = s1_data;
  end

  // Gating with rst drops a result that would otherwise surface during reset.
  always_comb begin
    rvalid = '0;
    if (o_valid && !rst) rvalid[o_ch] = 1'b1;
  end

  assign rdata = o_data;
  assign rerr  = o_err;

endmodule

// File: tb/tb_rr_shared_rom.sv
// Bench for rr_shared_rom: two instances (OUT_REG=0/1) on shared stimulus, checked against a queue model.
module tb_rr_shared_rom;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 1000;
  localparam int EW    = 43;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    req = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH-1:0]    gnt0, gnt1, rv0, rv1;
  logic [DW-1:0]     rd0, rd1;
  logic              re0, re1;

  always #5 clk = ~clk;

  rr_shared_rom #(.INIT_FILE(""), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                  .NUM_CH(NCH), .OUT_REG(0)) u_rom0 (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .gnt(gnt0), .rvalid(rv0), .rdata(rd0), .rerr(re0)
  );

  rr_shared_rom #(.INIT_FILE(""), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                  .NUM_CH(NCH), .OUT_REG(1)) u_rom1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .rerr(re1)
  );

  int             errors = 0;
  int             checks = 0;
  int             cyc = 0;
  bit             running = 1'b1;
  logic [DW-1:0]  mem_model [DEPTH];
  int             mdl_ptr = 0;
  logic [NCH-1:0] mdl_gnt = '0;
  logic [EW-1:0]  exp_q0[$];
  logic [EW-1:0]  exp_q1[$];
  logic [DW-1:0]  held_d [2];
  logic           held_e [2];
  int             wait_cnt [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One output port set against the model queue for that instance.
  task automatic check_out(input int d, input string pfx, input logic [NCH-1:0] rv,
                           input logic [DW-1:0] rd, input logic re);
    logic [EW-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    if (d == 0) begin
      if (exp_q0.size() > 0 && int'(exp_q0[0][42:11]) == cyc) begin
        e = exp_q0.pop_front();
        have = 1'b1;
      end
    end else begin
      if (exp_q1.size() > 0 && int'(exp_q1[0][42:11]) == cyc) begin
        e = exp_q1.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      chk({pfx, "_rvalid"}, 32'(rv), 32'(1) << e[10:9]);
      chk({pfx, "_rdata"}, 32'(rd), 32'(e[7:0]));
      chk({pfx, "_rerr"}, 32'(re), 32'(e[8]));
      held_d[d] = e[7:0];
      held_e[d] = e[8];
    end else begin
      chk({pfx, "_rvalid_idle"}, 32'(rv), 32'(0));
      chk({pfx, "_rdata_hold"}, 32'(rd), 32'(held_d[d]));
      chk({pfx, "_rerr_hold"}, 32'(re), 32'(held_e[d]));
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom_range(0, 255));
      if (i == 0)   v = 8'h3C;
      if (i == 1)   v = 8'hC3;
      if (i == 5)   v = 8'hA5;
      if (i == 999) v = 8'h5A;
      mem_model[i]  = v;
      u_rom0.mem[i] = v;
      u_rom1.mem[i] = v;
    end
  end

  // Model: priority search from ptr, fixed latency 1 or 2, drop everything on reset.
  initial begin
    logic [NCH-1:0] eg;
    int             gk;
    int             worst;
    logic [AW-1:0]  a;
    logic           err;
    logic [DW-1:0]  d;
    held_d[0] = '0; held_d[1] = '0;
    held_e[0] = 1'b0; held_e[1] = 1'b0;
    for (int j = 0; j < NCH; j++) wait_cnt[j] = 0;
    while (running) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("gnt0_in_reset", 32'(gnt0), 32'(0));
        chk("gnt1_in_reset", 32'(gnt1), 32'(0));
        chk("rvalid0_in_reset", 32'(rv0), 32'(0));
        chk("rvalid1_in_reset", 32'(rv1), 32'(0));
        exp_q0.delete();
        exp_q1.delete();
        held_d[0] = '0; held_d[1] = '0;
        held_e[0] = 1'b0; held_e[1] = 1'b0;
        mdl_ptr = 0;
        mdl_gnt = '0;
        for (int j = 0; j < NCH; j++) wait_cnt[j] = 0;
      end else begin
        eg = '0;
        gk = 0;
        for (int j = 0; j < NCH; j++) begin
          if (eg == '0 && req[(mdl_ptr + j) % NCH]) begin
            gk = (mdl_ptr + j) % NCH;
            eg[gk] = 1'b1;
          end
        end
        chk("gnt0", 32'(gnt0), 32'(eg));
        chk("gnt1", 32'(gnt1), 32'(eg));
        check_out(0, "u0", rv0, rd0, re0);
        check_out(1, "u1", rv1, rd1, re1);
        if (eg != '0) begin
          a   = addr[gk*AW +: AW];
          err = (int'(a) >= DEPTH);
          d   = err ? '0 : mem_model[a];
          exp_q0.push_back({32'(cyc + 1), 2'(gk), err, d});
          exp_q1.push_back({32'(cyc + 2), 2'(gk), err, d});
          mdl_ptr = (gk + 1) % NCH;
        end
        mdl_gnt = eg;
        worst = 0;
        for (int j = 0; j < NCH; j++) begin
          if (!req[j] || gnt0[j]) wait_cnt[j] = 0;
          else if (gnt0 != '0) wait_cnt[j]++;
          if (wait_cnt[j] > worst) worst = wait_cnt[j];
        end
        if (req != '0) chk("wait_bound_exceeded", 32'(worst > NCH - 1), 32'(0));
      end
    end
  end

  task automatic drive(input logic r, input logic [NCH-1:0] q,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    @(posedge clk);
    #1;
    rst  = r;
    req  = q;
    addr = {a3, a2, a1, a0};
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [NCH-1:0] pend;
    logic [AW-1:0]  paddr [NCH];
    logic           rr;
    #200_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] pend;
    logic [AW-1:0]  paddr [NCH];
    logic           rr;
    rst = 1'b1; req = 4'b0011; addr = '0;
    repeat (3) drive(1'b1, 4'b0011, 0, 0, 0, 0);
    peek();
    chk("lit_reset_gnt", 32'(gnt0), 32'(0));
    chk("lit_reset_rvalid", 32'(rv0), 32'(0));
    chk("lit_reset_rdata0", 32'(rd0), 32'(0));
    chk("lit_reset_rdata1", 32'(rd1), 32'(0));

    drive(1'b0, 4'b0011, 0, 1, 0, 0);
    peek();
    chk("lit_first_gnt", 32'(gnt0), 32'h1);
    drive(1'b0, 4'b0011, 0, 1, 0, 0);
    peek();
    chk("lit_alt_gnt_b", 32'(gnt0), 32'h2);
    chk("lit_alt_rv0_b", 32'(rv0), 32'h1);
    chk("lit_alt_rd0_b", 32'(rd0), 32'h3C);
    drive(1'b0, 4'b0011, 0, 1, 0, 0);
    peek();
    chk("lit_alt_gnt_c", 32'(gnt0), 32'h1);
    chk("lit_alt_rd0_c", 32'(rd0), 32'hC3);
    chk("lit_alt_rd1_c", 32'(rd1), 32'h3C);
    drive(1'b0, 4'b0010, 0, 1, 0, 0);
    peek();
    chk("lit_alt_gnt_d", 32'(gnt0), 32'h2);
    chk("lit_alt_rv1_d", 32'(rv1), 32'h2);
    drive(1'b0, 4'b0000, 0, 0, 0, 0);

    drive(1'b0, 4'b0001, 5, 0, 0, 0);
    peek();
    chk("lit_a5_gnt", 32'(gnt0), 32'h1);
    drive(1'b0, 4'b0000, 0, 0, 0, 0);
    peek();
    chk("lit_a5_rv0", 32'(rv0), 32'h1);
    chk("lit_a5_rd0", 32'(rd0), 32'hA5);
    chk("lit_a5_rv1_early", 32'(rv1), 32'h0);
    drive(1'b0, 4'b0000, 0, 0, 0, 0);
    peek();
    chk("lit_a5_rv1", 32'(rv1), 32'h1);
    chk("lit_a5_rd1", 32'(rd1), 32'hA5);
    chk("lit_a5_rd0_hold", 32'(rd0), 32'hA5);

    drive(1'b0, 4'b0100, 0, 0, 1500, 0);
    peek();
    chk("lit_oor_gnt", 32'(gnt0), 32'h4);
    drive(1'b0, 4'b0100, 0, 0, 999, 0);
    peek();
    chk("lit_oor_rv0", 32'(rv0), 32'h4);
    chk("lit_oor_rerr", 32'(re0), 32'h1);
    chk("lit_oor_rdata", 32'(rd0), 32'h0);
    drive(1'b0, 4'b0000, 0, 0, 0, 0);
    peek();
    chk("lit_last_rerr", 32'(re0), 32'h0);
    chk("lit_last_rdata", 32'(rd0), 32'h5A);

    drive(1'b0, 4'b1000, 0, 0, 0, 7);
    peek();
    chk("lit_drop_gnt", 32'(gnt0), 32'h8);
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    peek();
    chk("lit_drop_rv0", 32'(rv0), 32'h0);
    drive(1'b0, 4'b0000, 0, 0, 0, 0);
    peek();
    chk("lit_drop_rv1", 32'(rv1), 32'h0);
    drive(1'b0, 4'b1111, 1, 2, 3, 4);
    peek();
    chk("lit_ptr_after_reset", 32'(gnt0), 32'h1);

    pend = 4'b1111;
    paddr[0] = 1; paddr[1] = 2; paddr[2] = 3; paddr[3] = 4;
    for (int n = 0; n < 8000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i] || mdl_gnt[i]) begin
          pend[i]  = ($urandom_range(0, 3) != 0);
          paddr[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1000, 2047))
                                                 : AW'($urandom_range(0, 999));
        end
      end
      rr = ($urandom_range(0, 599) == 0);
      drive(rr, pend, paddr[0], paddr[1], paddr[2], paddr[3]);
    end

    repeat (4) drive(1'b0, 4'b0000, 0, 0, 0, 0);
    running = 1'b0;
    @(negedge clk);
    #2;
    chk("drain_q0_empty", 32'(exp_q0.size()), 32'(0));
    chk("drain_q1_empty", 32'(exp_q1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
